// File: rtl/coproc_pkg.sv
// Shared types and defaults for the pixel processing element.
package coproc_pkg;

    localparam int unsigned CH_W_DEF = 4;
    localparam int unsigned NCH_DEF  = 3;

    typedef enum logic [2:0] {
        FnPass    = 3'b000,
        FnBlur    = 3'b001,
        FnSharpen = 3'b010,
        FnSobelX  = 3'b011,
        FnSobelY  = 3'b100,
        FnEdge    = 3'b101,
        FnEmboss  = 3'b110,
        FnInvert  = 3'b111
    } func_e;

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StDone
    } state_e;

endpackage

// File: rtl/pe_kernel_mac.sv
// Combinational 3x3 kernel evaluator for one channel; result clamped to [0, 2^CH_W-1].
module pe_kernel_mac
    import coproc_pkg::*;
#(
    parameter int unsigned CH_W = CH_W_DEF
) (
    input  func_e             func,
    input  logic [9*CH_W-1:0] win,     // sample r*3+c, top-left at index 0
    output logic [CH_W-1:0]   result
);

    localparam int unsigned AW = CH_W + 6;
    localparam logic signed [AW-1:0] MaxV = $signed({6'b0, {CH_W{1'b1}}});

    logic signed [AW-1:0] s [9];
    logic signed [AW-1:0] gx, gy, acc;

    for (genvar i = 0; i < 9; i++) begin : g_ext
        assign s[i] = $signed({6'b0, win[i*CH_W +: CH_W]});
    end

    function automatic logic signed [AW-1:0] abs_v(input logic signed [AW-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    assign gx = (s[2] - s[0]) + ((s[5] - s[3]) <<< 1) + (s[8] - s[6]);
    assign gy = (s[6] - s[0]) + ((s[7] - s[1]) <<< 1) + (s[8] - s[2]);

    always_comb begin
        acc = s[4];
        unique case (func)
            FnPass:    acc = s[4];
            FnBlur:    acc = (s[0] + s[2] + s[6] + s[8]
                             + ((s[1] + s[3] + s[5] + s[7]) <<< 1) + (s[4] <<< 2)) >>> 4;
            FnSharpen: acc = (s[4] <<< 2) + s[4] - s[1] - s[3] - s[5] - s[7];
            FnSobelX:  acc = abs_v(gx);
            FnSobelY:  acc = abs_v(gy);
            FnEdge:    acc = abs_v(gx) + abs_v(gy);
            FnEmboss:  acc = ((s[8] - s[0]) <<< 1) - s[1] - s[3] + s[4] + s[5] + s[7];
            FnInvert:  acc = MaxV - s[4];
            default:   acc = s[4];
        endcase
    end

    always_comb begin
        if (acc < 0) begin
            result = '0;
        end else if (acc > MaxV) begin
            result = '1;
        end else begin
            result = acc[CH_W-1:0];
        end
    end

endmodule

// File: rtl/proc_element_par.sv
// 3x3 window processing element: captures a window, runs one channel per cycle through a
// shared kernel unit (or one gray pass), then strobes we with the registered result.
module proc_element_par
    import coproc_pkg::*;
#(
    parameter  int unsigned CH_W  = CH_W_DEF,
    parameter  int unsigned NCH   = NCH_DEF,
    localparam int unsigned PIX_W = NCH * CH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3*PIX_W-1:0] rgb_in0,
    input  logic [3*PIX_W-1:0] rgb_in1,
    input  logic [3*PIX_W-1:0] rgb_in2,
    input  logic [2:0]         func,
    input  logic               gray,
    input  logic               start,
    output logic               rdy,
    output logic               we,
    output logic [PIX_W-1:0]   data_out
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SW = CH_W + $clog2(NCH) + 2;

    state_e             state_q, state_d;
    logic [CW-1:0]      ch_cnt_q, ch_cnt_d;
    logic [3*PIX_W-1:0] rows_q [3];
    func_e              func_q;
    logic               gray_q;
    logic [PIX_W-1:0]   res_q, res_d;
    logic [PIX_W-1:0]   data_out_q, data_out_d;
    logic [9*CH_W-1:0]  win;
    logic [PIX_W-1:0]   pix;
    logic [CH_W-1:0]    mac_res;
    logic               last_ch;

    // NCH=3 uses the luma-like (c0 + 2*c1 + c2) >> 2, otherwise a plain truncated mean.
    function automatic logic [CH_W-1:0] gray_of(input logic [PIX_W-1:0] px);
        logic [SW-1:0] acc;
        logic [SW-1:0] q;
        acc = '0;
        for (int k = 0; k < NCH; k++) begin
            acc = acc + SW'(px[k*CH_W +: CH_W]);
            if (NCH == 3 && k == 1) begin
                acc = acc + SW'(px[k*CH_W +: CH_W]);
            end
        end
        q = (NCH == 3) ? (acc >> 2) : (acc / SW'(NCH));
        return q[CH_W-1:0];
    endfunction

    always_comb begin
        win = '0;
        pix = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pix = rows_q[r][(2-c)*PIX_W +: PIX_W];
                if (gray_q) begin
                    win[(r*3+c)*CH_W +: CH_W] = gray_of(pix);
                end else begin
                    win[(r*3+c)*CH_W +: CH_W] = pix[int'(ch_cnt_q)*CH_W +: CH_W];
                end
            end
        end
    end

    pe_kernel_mac #(
        .CH_W (CH_W)
    ) u_mac (
        .func   (func_q),
        .win    (win),
        .result (mac_res)
    );

    assign last_ch = gray_q || (ch_cnt_q == CW'(NCH - 1));

    always_comb begin
        state_d    = state_q;
        ch_cnt_d   = ch_cnt_q;
        res_d      = res_q;
        data_out_d = data_out_q;
        rdy        = 1'b0;
        we         = 1'b0;
        unique case (state_q)
            StIdle: begin
                rdy = 1'b1;
                if (start) begin
                    state_d  = StCompute;
                    ch_cnt_d = '0;
                end
            end
            StCompute: begin
                if (gray_q) begin
                    res_d = {NCH{mac_res}};
                end else begin
                    res_d[int'(ch_cnt_q)*CH_W +: CH_W] = mac_res;
                end
                if (last_ch) begin
                    state_d    = StDone;
                    ch_cnt_d   = '0;
                    data_out_d = res_d;
                end else begin
                    ch_cnt_d = ch_cnt_q + CW'(1);
                end
            end
            StDone: begin
                we      = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ch_cnt_q   <= '0;
            res_q      <= '0;
            data_out_q <= '0;
            rows_q     <= '{default: '0};
            func_q     <= FnPass;
            gray_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_cnt_q   <= ch_cnt_d;
            res_q      <= res_d;
            data_out_q <= data_out_d;
            if (state_q == StIdle && start) begin
                rows_q[0] <= rgb_in0;
                rows_q[1] <= rgb_in1;
                rows_q[2] <= rgb_in2;
                func_q    <= func_e'(func);
                gray_q    <= gray;
            end
        end
    end

    assign data_out = data_out_q;

endmodule

// File: doc/proc_element_par.md
PROC_ELEMENT_PAR -- requirements
Module: proc_element_par

Interface
- REQ-001 Parameter CH_W, default 4: bits per colour channel.
- REQ-002 Parameter NCH, default 3: channels per pixel (ch NCH-1 at MSBs, e.g. R,G,B).
- REQ-003 Parameter PIX_W, fixed at NCH*CH_W (default 12): pixel width.
- REQ-004 Port clk, input, 1: single clock; all state changes on rising edge.
- REQ-005 Port rst, input, 1: reset, synchronous and active-high.
- REQ-006 Ports rgb_in0/rgb_in1/rgb_in2, input, 3*PIX_W each: window rows top/middle/bottom; left pixel at MSBs, centre in the middle field.
- REQ-007 Port func, input, 3: kernel select, per REQ-014.
- REQ-008 Port gray, input, 1: grayscale mode.
- REQ-009 Port start, input, 1: request; accepted only when start=1 and rdy=1 at a rising edge.
- REQ-010 Port rdy, output, 1: idle, able to accept.
- REQ-011 Port we, output, 1: one-cycle strobe; data_out valid.
- REQ-012 Port data_out, output, PIX_W: result pixel.

Function
- REQ-013 On accept: capture rows, func and gray into internal registers; later input changes have no effect on the operation.
- REQ-014 func codes, per channel over the 3x3 window:
  - 000 pass: centre.
  - 001 blur: [1 2 1;2 4 2;1 2 1] >>4.
  - 010 sharpen: [0 -1 0;-1 5 -1;0 -1 0].
  - 011 sobel-x: |[-1 0 1;-2 0 2;-1 0 1]|.
  - 100 sobel-y: |transposed sobel-x|.
  - 101 edge: |gx|+|gy|.
  - 110 emboss: [-2 -1 0;-1 1 1;0 1 2].
  - 111 invert: (2^CH_W-1)-centre.
- REQ-015 Arithmetic: signed accumulator CH_W+6 bits; result clamped to [0, 2^CH_W-1] (negative->0, overflow->max); no wrap-around.
- REQ-016 Gray mode: each window pixel is first reduced to gray value g=(ch0+2*ch1+ch2)>>2 (NCH=3; for other NCH, mean of channels truncated); a single kernel pass runs on g; the result is replicated into every channel of data_out.
- REQ-017 FSM states IDLE, COMPUTE, DONE.
  - IDLE->COMPUTE on accept.
  - COMPUTE processes one channel per cycle, ch_cnt 0..NCH-1, writing that channel's field of the result register.
  - COMPUTE->DONE after the last channel (after one cycle if gray=1).
  - DONE->IDLE unconditionally.
- REQ-018 rdy=1 only in IDLE; we=1 only in DONE.
- REQ-019 Latency: we asserted in the cycle after edge E0+NCH (gray: E0+1), where E0 is the accept edge; next accept possible at edge E0+NCH+2.
- REQ-020 start while rdy=0: ignored; no queueing; in-flight operation unaffected.
- REQ-021 data_out holds the last result until the next DONE; it is undefined-free (registered) at all times.

Reset
- REQ-022 rst=1 at an edge forces state IDLE, rdy=1, we=0, data_out=0, ch_cnt=0, regardless of state; start in a reset cycle is ignored.
- REQ-023 Reset during COMPUTE or DONE aborts the operation; no we pulse is produced for it.

Structure
- REQ-024 Shared package coproc_pkg holds the func code enum, FSM state enum and CH_W/NCH defaults.
- REQ-025 Sub-module pe_kernel_mac is combinational: 9 CH_W-bit samples plus func in, one clamped CH_W-bit result out; it is instantiated once and time-shared across channels.

Verification
- REQ-026 Rows 36'h000111222 / 36'h333444555 / 36'h666777888, func=000, gray=0, start pulse -> we high exactly 4 cycles after the accept edge, data_out=12'h444; rdy low for 4 cycles.
- REQ-027 Same rows, func=111 -> data_out=12'hBBB; all-0x777 window with func=001 -> 12'h777; all-0x555 window with func=010 -> 12'h555.
- REQ-028 Left column 12'h000, middle and right columns 12'hFFF, func=011 -> 12'hFFF (saturated); mirrored window -> 12'h000 before abs is not reported, i.e. 12'hFFF after abs.
- REQ-029 Centre 12'hF00, func=000, gray=1 -> data_out=12'h333, we 2 cycles after accept.
- REQ-030 Second start while busy, plus func changed mid-op -> only one we pulse, result from the original func; rst asserted mid-COMPUTE -> no we pulse, rdy=1 and data_out=0 next cycle.
